// File: rtl/dequant_zigzag_pkg.sv
// dequant_zigzag shared types and tables.
// Zigzag scan-to-natural LUT, coefficient type, FSM states.
package dequant_zigzag_pkg;

  typedef logic signed [11:0] coef_t;

  typedef enum logic [1:0] {
    IDLE,
    PROC,
    OUT
  } dq_state_t;

  localparam logic [5:0] ZIGZAG_LUT [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

endpackage

// File: rtl/dequant_zigzag_lane.sv
// dequant_lane: one coefficient times one quantiser,
// saturated to OUT_W signed bits. Purely combinational.
module dequant_lane
  import dequant_zigzag_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  coef_t                   coef,
  input  logic [7:0]              q,
  output logic signed [OUT_W-1:0] res
);

  localparam longint MAXV = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint MINV = -MAXV - 1;
  localparam logic [63:0] MAXB = MAXV;
  localparam logic [63:0] MINB = MINV;

  logic signed [20:0] prod;
  logic signed [63:0] p;

  assign prod = coef * $signed({1'b0, q});
  assign p    = {{43{prod[20]}}, prod};

  // clamp the wide product into the output range
  always_comb begin
    res = p[OUT_W-1:0];
    if (p > MAXV)
      res = MAXB[OUT_W-1:0];
    else if (p < MINV)
      res = MINB[OUT_W-1:0];
  end

endmodule

// File: rtl/dequant_zigzag.sv
// dequant_zigzag: zigzag block in, dequantised natural-order
// block out. Optional DC predictor under macro DC_PRED_EN.
module dequant_zigzag
  import dequant_zigzag_pkg::*;
#(
  parameter int LANES = 8,
  parameter int OUT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [64*12-1:0]      data_in,
  input  logic                  valid_in,
  input  logic                  qt_wr_en,
  input  logic [5:0]            qt_addr,
  input  logic [7:0]            qt_data,
  input  logic                  dc_clear,
  output logic [64*OUT_W-1:0]   data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy,
  output logic                  overflow
);

  localparam int STEPS = 64 / LANES;
  localparam logic [5:0] LAST = 6'(STEPS - 1);

  dq_state_t               state;
  logic [64*12-1:0]        pend;
  logic                    pend_valid;
  coef_t                   work [64];
  logic [7:0]              qt [64];
  logic [5:0]              step;
  logic signed [OUT_W-1:0] dout [64];
  logic [LANES*6-1:0]      kflat;
  logic [LANES*OUT_W-1:0]  lane_res;
  logic                    hs;
  logic                    consume;

  assign hs      = valid_out && ready_in;
  assign consume = pend_valid &&
                   ((state == IDLE) || (state == OUT && hs));
  assign busy    = (state != IDLE) || pend_valid;

  for (genvar i = 0; i < 64; i++) begin : g_dout
    assign data_out[i*OUT_W +: OUT_W] = dout[i];
  end

`ifdef DC_PRED_EN
  coef_t dc_pred;
  coef_t dc_base;
  coef_t dc_sum;
  logic  unused_dc;

  assign unused_dc = 1'b0;
  assign dc_base   = dc_clear ? '0 : dc_pred;
  assign dc_sum    = dc_base + work[0];

  // running DC predictor, updated on the k=0 step
  always_ff @(posedge clk) begin
    if (rst)
      dc_pred <= '0;
    else if (state == PROC && step == 6'd0)
      dc_pred <= dc_sum;
    else if (dc_clear)
      dc_pred <= '0;
  end
`else
  logic unused_dc;
  assign unused_dc = dc_clear;
`endif

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [5:0] k;
    coef_t      c;
    assign k = step * 6'(LANES) + 6'(j);
    assign kflat[j*6 +: 6] = k;
`ifdef DC_PRED_EN
    if (j == 0) begin : g_dc
      assign c = (step == 6'd0) ? dc_sum : work[k];
    end else begin : g_raw
      assign c = work[k];
    end
`else
    assign c = work[k];
`endif
    dequant_lane #(
      .OUT_W(OUT_W)
    ) u_lane (
      .coef(c),
      .q   (qt[k]),
      .res (lane_res[j*OUT_W +: OUT_W])
    );
  end

  // pend capture, quant table, and the IDLE/PROC/OUT sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pend       <= '0;
      pend_valid <= 1'b0;
      step       <= '0;
      valid_out  <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < 64; i++) begin
        dout[i] <= '0;
        qt[i]   <= 8'd1;
        work[i] <= '0;
      end
    end else begin
      if (qt_wr_en)
        qt[qt_addr] <= qt_data;

      if (valid_in && (!pend_valid || consume)) begin
        pend       <= data_in;
        pend_valid <= 1'b1;
      end else if (consume) begin
        pend_valid <= 1'b0;
      end

      if (valid_in && pend_valid && !consume)
        overflow <= 1'b1;

      unique case (state)
        IDLE: begin
          if (pend_valid) begin
            for (int i = 0; i < 64; i++)
              work[i] <= pend[i*12 +: 12];
            step  <= '0;
            state <= PROC;
          end
        end
        PROC: begin
          for (int j = 0; j < LANES; j++)
            dout[ZIGZAG_LUT[kflat[j*6 +: 6]]] <=
              lane_res[j*OUT_W +: OUT_W];
          step <= step + 6'd1;
          if (step == LAST) begin
            state     <= OUT;
            valid_out <= 1'b1;
          end
        end
        OUT: begin
          if (hs) begin
            valid_out <= 1'b0;
            if (pend_valid) begin
              for (int i = 0; i < 64; i++)
                work[i] <= pend[i*12 +: 12];
              step  <= '0;
              state <= PROC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dequant_zigzag.sv
// tb_dequant_zigzag: directed vectors, hand-computed results.
// Expected DC values follow the DC_PRED_EN build setting.
module tb_dequant_zigzag;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [767:0]     data_in = '0;
  logic             valid_in = 1'b0;
  logic             qt_wr_en = 1'b0;
  logic [5:0]       qt_addr = '0;
  logic [7:0]       qt_data = '0;
  logic             dc_clear = 1'b0;
  logic [1023:0]    data_out;
  logic             valid_out;
  logic             ready_in = 1'b0;
  logic             busy;
  logic             overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  dequant_zigzag #(
    .LANES(8),
    .OUT_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .valid_in (valid_in),
    .qt_wr_en (qt_wr_en),
    .qt_addr  (qt_addr),
    .qt_data  (qt_data),
    .dc_clear (dc_clear),
    .data_out (data_out),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint out_at(input int i);
    logic signed [15:0] v;
    v = data_out[i*16 +: 16];
    return longint'(v);
  endfunction

  function automatic logic [767:0] mk(input int c0, input int c1,
                                      input int c2);
    logic [767:0] d;
    d = '0;
    d[11:0]  = 12'(c0);
    d[23:12] = 12'(c1);
    d[35:24] = 12'(c2);
    return d;
  endfunction

  task automatic send(input logic [767:0] d);
    @(negedge clk);
    data_in  = d;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_vo(input string tag, output int c);
    c = 0;
    while (!valid_out && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (!valid_out)
      chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic accept();
    @(negedge clk);
    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
  endtask

  task automatic qt_fill(input logic [7:0] v);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      qt_wr_en = 1'b1;
      qt_addr  = 6'(i);
      qt_data  = v;
    end
    @(negedge clk);
    qt_wr_en = 1'b0;
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [767:0] d;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_data_out0", out_at(0), 0);

    // 1: ramp block, qt all 1
    d = '0;
    for (int k = 0; k < 64; k++)
      d[k*12 +: 12] = 12'(k);
    send(d);
    wait_vo("t1", cyc);
    chk("t1_latency", cyc + 1, 10);
    chk("t1_out0", out_at(0), 0);
    chk("t1_out1", out_at(1), 1);
    chk("t1_out8", out_at(8), 2);
    chk("t1_out16", out_at(16), 3);
    chk("t1_out9", out_at(9), 4);
    chk("t1_out2", out_at(2), 5);
    chk("t1_out63", out_at(63), 63);
    chk("t1_out7", out_at(7), 28);
    accept();
    chk("t1_vo_after_hs", valid_out, 0);
    chk("t1_busy_after_hs", busy, 0);

    // 2: qt all 255, saturation both ways
    qt_fill(8'd255);
    send(mk(-2048, 100, 2047));
    wait_vo("t2", cyc);
    chk("t2_out0_negsat", out_at(0), -32768);
    chk("t2_out1", out_at(1), 25500);
    chk("t2_out8_possat", out_at(8), 32767);
    chk("t2_out16", out_at(16), 0);
    accept();

    // 3: stalled downstream, third block dropped
    do_rst();
    send(mk(0, 11, 0));
    wait_vo("t3a", cyc);
    send(mk(0, 22, 0));
    send(mk(0, 33, 0));
    chk("t3_overflow", overflow, 1);
    chk("t3_busy", busy, 1);
    chk("t3_first_held", out_at(1), 11);
    accept();
    wait_vo("t3b", cyc);
    chk("t3_second", out_at(1), 22);
    accept();
    repeat (15) @(negedge clk);
    chk("t3_third_dropped", valid_out, 0);
    chk("t3_idle", busy, 0);
    chk("t3_overflow_sticky", overflow, 1);

    // 4: handshake coinciding with valid_in while pend full
    do_rst();
    chk("t4_overflow_clr", overflow, 0);
    send(mk(0, 1, 0));
    wait_vo("t4a", cyc);
    send(mk(0, 2, 0));
    @(negedge clk);
    data_in  = mk(0, 3, 0);
    valid_in = 1'b1;
    ready_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    ready_in = 1'b0;
    chk("t4_no_overflow", overflow, 0);
    wait_vo("t4b", cyc);
    chk("t4_second", out_at(1), 2);
    accept();
    wait_vo("t4c", cyc);
    chk("t4_third", out_at(1), 3);
    accept();
    chk("t4_no_overflow_end", overflow, 0);

    // 5: DC predictor behaviour
    @(negedge clk);
    dc_clear = 1'b1;
    @(negedge clk);
    dc_clear = 1'b0;
    send(mk(5, 0, 0));
    wait_vo("t5a", cyc);
    chk("t5_dc0", out_at(0), 5);
    accept();
    send(mk(-3, 0, 0));
    wait_vo("t5b", cyc);
`ifdef DC_PRED_EN
    chk("t5_dc1", out_at(0), 2);
`else
    chk("t5_dc1", out_at(0), -3);
`endif
    accept();
    @(negedge clk);
    dc_clear = 1'b1;
    @(negedge clk);
    dc_clear = 1'b0;
    send(mk(4, 0, 0));
    wait_vo("t5c", cyc);
    chk("t5_dc2", out_at(0), 4);
    accept();

    // 6: reset mid-PROC
    @(negedge clk);
    qt_wr_en = 1'b1;
    qt_addr  = 6'd1;
    qt_data  = 8'd7;
    @(negedge clk);
    qt_wr_en = 1'b0;
    send(mk(0, 9, 0));
    repeat (3) @(negedge clk);
    chk("t6_busy_mid", busy, 1);
    do_rst();
    chk("t6_vo_after_rst", valid_out, 0);
    chk("t6_busy_after_rst", busy, 0);
    send(mk(0, 9, 0));
    wait_vo("t6", cyc);
    chk("t6_latency", cyc + 1, 10);
    chk("t6_qt_reverted", out_at(1), 9);
    accept();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
